tick_sequencer: RTL and testbench

//  Consumes the four slow square waves from the clock divider (0.25/0.5/1/2 Hz) and turns the

---
 rtl/tick_sequencer_pkg.sv | 19 +
 rtl/tick_sequencer_slow_clk_sync.sv | 16 +
 rtl/tick_sequencer.sv | 113 +++++++++++
 tb/tb_tick_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tick_sequencer_pkg.sv
// tick_sequencer_pkg: shared encodings and helpers for the tick sequencer
//   SPD_*     speed_sel encodings (index of the selected divider output)
//   state_t   FSM state encodings, also the value driven on the state port
//   to_bcd    integer 0..99 to packed two-digit BCD
package tick_sequencer_pkg;
   localparam logic [1:0] SPD_025HZ = 2'b00;
   localparam logic [1:0] SPD_05HZ  = 2'b01;
   localparam logic [1:0] SPD_1HZ   = 2'b10;
   localparam logic [1:0] SPD_2HZ   = 2'b11;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;
   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction
endpackage

// File: rtl/tick_sequencer_slow_clk_sync.sv
// tick_sequencer_slow_clk_sync: two-flop synchroniser for one slow divider output
//   CLOCK_50  in   system clock
//   reset     in   asynchronous, active-high
//   d         in   asynchronous level
//   q         out  level synchronised to CLOCK_50
module tick_sequencer_slow_clk_sync (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) {q, meta} <= 2'b00;
      else       {q, meta} <= {meta, d};
endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer: turns a selected slow square wave into single-cycle ticks that step
// a run/pause/done FSM driving a bouncing one-hot LED sweep and a BCD step counter
//   CLOCK_50   in   system clock
//   reset      in   asynchronous, active-high
//   C025Hz..C2Hz in slow square waves, treated as data
//   speed_sel  in   selects which square wave produces ticks
//   start      in   one-cycle pulse: (re)start a run from step 00
//   pause      in   one-cycle pulse: toggle RUN/PAUSE
//   tick       out  registered one-cycle pulse per selected rising edge
//   state      out  FSM state
//   leds       out  one-hot sweep position, all ones when done
//   step_bcd   out  two-digit BCD steps taken in the current run
//   done       out  high while in DONE
module tick_sequencer
   import tick_sequencer_pkg::*;
#(
   parameter int LED_W     = 8,
   parameter int MAX_STEPS = 60
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             C025Hz,
   input  logic             C05Hz,
   input  logic             C1Hz,
   input  logic             C2Hz,
   input  logic [1:0]       speed_sel,
   input  logic             start,
   input  logic             pause,
   output logic             tick,
   output logic [1:0]       state,
   output logic [LED_W-1:0] leds,
   output logic [7:0]       step_bcd,
   output logic             done
);
   localparam int         PW   = (LED_W > 1) ? $clog2(LED_W) : 1;
   localparam logic [7:0] LAST = to_bcd(MAX_STEPS - 1);
   logic [3:0]    raw, sync;
   logic [1:0]    sel_q;
   logic [2:0]    warm;
   logic          lvl, prev, hold, rise;
   state_t        st, st_n;
   logic [PW-1:0] pos, pos_n;
   logic          up, up_n;
   logic [7:0]    step, step_n;
   assign raw[SPD_025HZ] = C025Hz;
   assign raw[SPD_05HZ]  = C05Hz;
   assign raw[SPD_1HZ]   = C1Hz;
   assign raw[SPD_2HZ]   = C2Hz;
   for (genvar i = 0; i < 4; i++) begin : g_sync
      tick_sequencer_slow_clk_sync u_sync (
         .CLOCK_50 (CLOCK_50),
         .reset    (reset),
         .d        (raw[i]),
         .q        (sync[i])
      );
   end
   assign lvl = sync[speed_sel];
   // Edges are suppressed while the source is switching and until the synchroniser has
   // been refilled after reset, so a source that is already high never produces a tick.
   assign hold = (speed_sel != sel_q) || !warm[2];
   assign rise = lvl && !prev && !hold;
   always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
         sel_q <= '0;
         warm  <= '0;
         prev  <= 1'b0;
         tick  <= 1'b0;
      end else begin
         sel_q <= speed_sel;
         warm  <= {warm[1:0], 1'b1};
         prev  <= lvl;
         tick  <= rise;
      end
   always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
         st   <= ST_IDLE;
         pos  <= '0;
         up   <= 1'b1;
         step <= '0;
      end else begin
         st   <= st_n;
         pos  <= pos_n;
         up   <= up_n;
         step <= step_n;
      end
   always_comb begin
      st_n   = st;
      pos_n  = pos;
      up_n   = up;
      step_n = step;
      if (start) begin
         st_n   = ST_RUN;
         pos_n  = '0;
         up_n   = 1'b1;
         step_n = '0;
      end else if (st == ST_RUN) begin
         if (rise) begin
            pos_n  = up ? pos + 1'b1 : pos - 1'b1;
            up_n   = up ? (pos_n != PW'(LED_W - 1)) : (pos_n == '0);
            step_n = (step[3:0] == 4'd9) ? {step[7:4] + 4'd1, 4'd0} : step + 8'd1;
         end
         st_n = (rise && step == LAST) ? ST_DONE : pause ? ST_PAUSE : ST_RUN;
      end else if (st == ST_PAUSE && pause) begin
         st_n = ST_RUN;
      end
   end
   always_comb begin
      leds = (st == ST_DONE) ? '1 : (st == ST_IDLE) ? '0 : LED_W'(1) << pos;
      done = (st == ST_DONE);
   end
   assign state    = st;
   assign step_bcd = step;
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed self-checking bench for tick_sequencer (LED_W=8, MAX_STEPS=12)
module tb_tick_sequencer;
   logic       CLOCK_50 = 1'b0;
   logic       reset, C025Hz, C05Hz, C1Hz, C2Hz, start, pause;
   logic [1:0] speed_sel;
   logic       tick, done;
   logic [1:0] state;
   logic [7:0] leds, step_bcd;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       seen;
   logic [7:0] exp_leds [10] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10};
   logic [7:0] exp_step [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

   always #5 CLOCK_50 = ~CLOCK_50;

   tick_sequencer #(.LED_W(8), .MAX_STEPS(12)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .C025Hz    (C025Hz),
      .C05Hz     (C05Hz),
      .C1Hz      (C1Hz),
      .C2Hz      (C2Hz),
      .speed_sel (speed_sel),
      .start     (start),
      .pause     (pause),
      .tick      (tick),
      .state     (state),
      .leds      (leds),
      .step_bcd  (step_bcd),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic pulse_pause;
      pause = 1'b1;
      cyc(1);
      pause = 1'b0;
   endtask

   // one C2Hz rising edge; tick must appear exactly three cycles later for one cycle
   task automatic tick2;
      C2Hz = 1'b1;
      cyc(2);
      check("tick_early", tick, 1'b0);
      cyc(1);
      check("tick", tick, 1'b1);
      C2Hz = 1'b0;
      cyc(1);
      check("tick_width", tick, 1'b0);
      cyc(3);
   endtask

   task automatic watch_no_tick(input int n);
      seen = 1'b0;
      repeat (n) begin
         cyc(1);
         if (tick) seen = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; C025Hz = 0; C05Hz = 0; C1Hz = 0; C2Hz = 0;
      start = 0; pause = 0; speed_sel = 2'b11;
      cyc(3);
      check("rst_tick", tick, 0);
      check("rst_state", state, 2'b00);
      check("rst_leds", leds, 8'h00);
      check("rst_step", step_bcd, 8'h00);
      check("rst_done", done, 0);
      reset = 1'b0;
      cyc(5);
      // single tick three cycles after the rising edge, none on the falling edge
      C2Hz = 1'b1;
      cyc(1); check("t1_c101", tick, 0);
      cyc(1); check("t1_c102", tick, 0);
      cyc(1); check("t1_c103", tick, 1);
      cyc(1); check("t1_c104", tick, 0);
      C2Hz = 1'b0;
      watch_no_tick(6);
      check("t1_fall", seen, 0);
      check("t1_idle_state", state, 2'b00);
      check("t1_idle_leds", leds, 8'h00);
      // sweep and BCD count
      pulse_start;
      check("t2_state", state, 2'b01);
      check("t2_leds0", leds, 8'h01);
      check("t2_step0", step_bcd, 8'h00);
      for (int i = 0; i < 10; i++) begin
         tick2;
         check($sformatf("t2_leds%0d", i + 1), leds, exp_leds[i]);
         check($sformatf("t2_step%0d", i + 1), step_bcd, exp_step[i]);
      end
      // run to completion with MAX_STEPS=12
      pulse_start;
      check("t3_restart_step", step_bcd, 8'h00);
      check("t3_restart_leds", leds, 8'h01);
      repeat (11) tick2;
      check("t3_s11_state", state, 2'b01);
      check("t3_s11_step", step_bcd, 8'h11);
      tick2;
      check("t3_state", state, 2'b11);
      check("t3_done", done, 1);
      check("t3_leds", leds, 8'hFF);
      check("t3_step", step_bcd, 8'h12);
      tick2;
      check("t3_hold_state", state, 2'b11);
      check("t3_hold_step", step_bcd, 8'h12);
      pulse_pause;
      check("t3_pause_ign", state, 2'b11);
      // pause freezes everything
      pulse_start;
      check("t4_run", done, 0);
      repeat (3) tick2;
      pulse_pause;
      check("t4_paused", state, 2'b10);
      repeat (5) tick2;
      check("t4_frz_state", state, 2'b10);
      check("t4_frz_step", step_bcd, 8'h03);
      check("t4_frz_leds", leds, 8'h08);
      pulse_pause;
      check("t4_resume", state, 2'b01);
      check("t4_resume_step", step_bcd, 8'h03);
      tick2;
      check("t4_next_step", step_bcd, 8'h04);
      check("t4_next_leds", leds, 8'h10);
      // asynchronous reset mid-run with the selected source held high
      pulse_start;
      repeat (7) tick2;
      check("t6_pre_step", step_bcd, 8'h07);
      C2Hz = 1'b1;
      cyc(1);
      reset = 1'b1;
      #1;
      check("t6_async_state", state, 2'b00);
      check("t6_async_leds", leds, 8'h00);
      check("t6_async_step", step_bcd, 8'h00);
      check("t6_async_tick", tick, 0);
      cyc(2);
      reset = 1'b0;
      watch_no_tick(8);
      check("t6_no_false_tick", seen, 0);
      C2Hz = 1'b0;
      cyc(4);
      tick2;
      check("t6_idle_state", state, 2'b00);
      start = 1'b1; pause = 1'b1;
      cyc(1);
      start = 1'b0; pause = 1'b0;
      check("t5_sp_state", state, 2'b01);
      check("t5_sp_leds", leds, 8'h01);
      // switching to a source that is already high must not tick
      C05Hz = 1'b1;
      cyc(5);
      speed_sel = 2'b01;
      watch_no_tick(6);
      check("t5_switch_tick", seen, 0);
      check("t5_switch_step", step_bcd, 8'h00);
      C05Hz = 1'b0;
      cyc(4);
      C05Hz = 1'b1;
      cyc(3);
      check("t5_new_edge", tick, 1);
      check("t5_new_step", step_bcd, 8'h01);
      check("t5_new_leds", leds, 8'h02);
      cyc(1);
      check("t5_new_width", tick, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
